mwaxis_tx_rr_arbiter: RTL and testbench
=======================================

Name: mwaxis_tx_rr_arbiter

Overview:
- Packet-level round-robin arbiter on the DUT clock domain.
- Merges up to 8 AXI-Stream slave channels into the single tx buffer write interface (data/datavld/eop/afull) that feeds the UDP packet builder.
- Tags every byte with the source channel index, which downstream logic maps to DSTPORT_n.
- Holds a grant for a whole packet (tlast to tlast) and splits any packet longer than MAXPKTLEN bytes.

Parameters:
- NUM_AXIS_CHANNELS, 8: number of slave channels; legal range 2..8.
- DATAWIDTH, 8: byte width of tdata and txbuffer_data.
- MAXPKTLEN, 1024: maximum bytes per emitted packet; legal range 2..4095.
- CHW, 3: channel index width; must equal clog2(NUM_AXIS_CHANNELS).

Ports:
- dutclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_AXIS_CHANNELS*DATAWIDTH  channel n occupies bits [n*DATAWIDTH +: DATAWIDTH].
- s_axis_tvalid  in  NUM_AXIS_CHANNELS  per-channel valid.
- s_axis_tlast  in  NUM_AXIS_CHANNELS  per-channel end of packet.
- s_axis_tready  out  NUM_AXIS_CHANNELS  per-channel ready; at most one bit high.
- txbuffer_data  out  DATAWIDTH  registered byte.
- txbuffer_datavld  out  1  byte strobe.
- txbuffer_eop  out  1  last byte of packet; qualified by datavld.
- txbuffer_chsel  out  CHW  source channel of the current byte; qualified by datavld.
- txbuffer_afull  in  1  tx buffer almost full; guarantees at least 2 further writes are accepted.
- arb_busy  out  1  high while a grant is held.
- pktcnt  out  NUM_AXIS_CHANNELS*16  per-channel completed-packet counters (see Optional Feature).

Behaviour:
- Reset values:
  - s_axis_tready, txbuffer_data, txbuffer_datavld, txbuffer_eop, txbuffer_chsel, arb_busy, pktcnt: all 0.
  - grant pointer = NUM_AXIS_CHANNELS-1, so channel 0 wins first.
  - byte counter = 0.
  - state = IDLE.
- FSM states: IDLE, XFER.
- IDLE:
  - Search tvalid starting at (last_grant+1) mod NUM and wrapping.
  - First valid channel found: register it as grant, go to XFER, arb_busy=1 next cycle.
  - No valid channel: stay in IDLE, tready=0.
- XFER:
  - s_axis_tready[grant] = !txbuffer_afull; this is combinational from the registered state and afull. All other tready bits are 0.
  - Handshake = tvalid[grant] & tready[grant].
  - On handshake, the next cycle has txbuffer_data=tdata, datavld=1, chsel=grant. Latency is exactly 1 cycle.
  - No handshake: datavld=0 next cycle; data/chsel hold their previous values.
  - Byte counter increments on each handshake (width 12, saturation never reached).
  - eop=1 on the registered byte if tlast=1 OR byte counter == MAXPKTLEN-1 at the handshake.
- End of packet:
  - On an eop handshake: clear byte counter, last_grant=grant, return to IDLE.
  - A MAXPKTLEN split counts as end of packet. The channel's remaining bytes compete again as a new packet, with no priority boost.
- Grant timing:
  - Minimum 1 idle cycle between packets: eop handshake cycle -> IDLE cycle -> new grant.
  - Peak throughput is MAXPKTLEN bytes per MAXPKTLEN+1 cycles.
- Boundary cases:
  - 1-byte packet (tlast on first beat): eop and datavld in the same output cycle.
  - afull asserted mid-packet: tready drops the same cycle; the grant is held, no byte is lost and none is duplicated.
  - tvalid dropping mid-packet: grant is held indefinitely; no timeout.
  - Single requesting channel: it is re-granted every packet.
  - Several channels valid simultaneously: strict rotation.
- Reset mid-packet: all state cleared at the next clock edge. A partial packet already written to the tx buffer is not terminated; the downstream reset owns cleanup.
- AXIS rule: tready never depends on tvalid.

Optional Feature:
- Macro: MWAXIS_ARB_PKTCNT_EN.
- Defined:
  - pktcnt[n*16 +: 16] increments on every eop handshake for channel n, MAXPKTLEN splits included.
  - Counters wrap from 16'hFFFF to 0.
  - Cleared by reset.
- Undefined: pktcnt is tied to 0 and no counter registers are generated. The port list is unchanged.

Test Plan:
- Channel 0 sends 4 bytes 0x11,0x22,0x33,0x44 with tlast on 0x44, afull=0 -> tready[0] rises 1 cycle after tvalid; datavld for 4 consecutive cycles, data 0x11..0x44, chsel=0, eop only on 0x44; arb_busy falls afterwards.
- Channels 1, 3 and 6 all hold 2-byte packets continuously -> grant order 1,3,6,1,3,6; 1 idle cycle between packets; tready one-hot throughout.
- Channel 2 streams 2500 bytes with tlast only on the last byte, MAXPKTLEN=1024 -> three packets of 1024, 1024 and 452 bytes, each with eop, all chsel=2.
- afull asserted for 5 cycles during byte 3 of a 10-byte packet -> tready low for exactly those 5 cycles; output sequence is 10 contiguous correct bytes with no gap-induced duplicates.
- reset pulsed for 1 cycle mid-packet on channel 5 -> next cycle all outputs are 0 and state is IDLE; channel 0 wins over channel 5 when both are valid afterwards.
- With MWAXIS_ARB_PKTCNT_EN: 3 packets on channel 4 plus one 1030-byte packet on channel 7 -> pktcnt ch4=3, ch7=2, all others 0. Without the macro: pktcnt=0 throughout.

Source files
------------

// File: rtl/mwaxis_tx_rr_arbiter_if.sv
// Bus bundle between the AXI-Stream source channels, the round-robin arbiter and the tx buffer write port.
// A byte moves on a channel only in a cycle where tvalid and tready are both high; tready never looks at tvalid.
interface mwaxis_tx_rr_arbiter_if #(
   parameter int NUM_AXIS_CHANNELS = 8,
   parameter int DATAWIDTH         = 8,
   parameter int CHW               = 3
);
   logic [NUM_AXIS_CHANNELS*DATAWIDTH-1:0] s_axis_tdata;
   logic [NUM_AXIS_CHANNELS-1:0]           s_axis_tvalid;
   logic [NUM_AXIS_CHANNELS-1:0]           s_axis_tlast;
   logic [NUM_AXIS_CHANNELS-1:0]           s_axis_tready;
   logic [DATAWIDTH-1:0]                   txbuffer_data;
   logic                                   txbuffer_datavld;
   logic                                   txbuffer_eop;
   logic [CHW-1:0]                         txbuffer_chsel;
   logic                                   txbuffer_afull;

   // Arbiter view: consumes the streams, writes the tx buffer.
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, txbuffer_afull,
      output s_axis_tready, txbuffer_data, txbuffer_datavld, txbuffer_eop, txbuffer_chsel
   );

   // Environment view: drives the streams and the buffer fill flag.
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, txbuffer_afull,
      input  s_axis_tready, txbuffer_data, txbuffer_datavld, txbuffer_eop, txbuffer_chsel
   );
endinterface

// File: rtl/mwaxis_tx_rr_arbiter.sv
// Packet-level round-robin arbiter: merges AXI-Stream channels into the tx buffer, splitting at MAXPKTLEN.
// Optional: define MWAXIS_ARB_PKTCNT_EN to build the per-channel completed-packet counters on pktcnt.
module mwaxis_tx_rr_arbiter #(
   parameter int NUM_AXIS_CHANNELS = 8,
   parameter int DATAWIDTH         = 8,
   parameter int MAXPKTLEN         = 1024,
   parameter int CHW               = 3
) (
   input  logic                           dutclk,
   input  logic                           reset,
   mwaxis_tx_rr_arbiter_if.slave          bus,
   output logic                           arb_busy,
   output logic [NUM_AXIS_CHANNELS*16-1:0] pktcnt,
   output logic                           dbg_state_o
);
   typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [CHW-1:0]       grant_q, grant_d;
   logic [11:0]          bytecnt_q, bytecnt_d;
   logic [DATAWIDTH-1:0] data_q, data_d;
   logic                 datavld_q, datavld_d;
   logic                 eop_q, eop_d;
   logic [CHW-1:0]       chsel_q, chsel_d;
   logic                 hs, eop_now, found;
   logic [CHW-1:0]       next_ch;

   function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_AXIS_CHANNELS) sum = sum - NUM_AXIS_CHANNELS;
      return CHW'(sum);
   endfunction

   // Scan from the farthest offset down so the nearest requester after the last grant wins.
   always_comb begin
      found   = 1'b0;
      next_ch = grant_q;
      for (int i = NUM_AXIS_CHANNELS; i >= 1; i--) begin
         if (bus.s_axis_tvalid[rr_idx(grant_q, i)]) begin
            found   = 1'b1;
            next_ch = rr_idx(grant_q, i);
         end
      end
   end

   assign hs      = (state_q == XFER) && bus.s_axis_tvalid[grant_q] && !bus.txbuffer_afull;
   assign eop_now = bus.s_axis_tlast[grant_q] || (bytecnt_q == 12'(MAXPKTLEN - 1));

   always_comb begin
      bus.s_axis_tready = '0;
      if (state_q == XFER) bus.s_axis_tready[grant_q] = !bus.txbuffer_afull;
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      bytecnt_d = bytecnt_q;
      data_d    = data_q;
      chsel_d   = chsel_q;
      datavld_d = 1'b0;
      eop_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = next_ch;
               state_d = XFER;
            end
         end
         XFER: begin
            if (hs) begin
               data_d    = bus.s_axis_tdata[grant_q*DATAWIDTH +: DATAWIDTH];
               datavld_d = 1'b1;
               chsel_d   = grant_q;
               eop_d     = eop_now;
               // grant_q stays as the last-granted channel for the next search
               if (eop_now) begin
                  bytecnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  bytecnt_d = bytecnt_q + 12'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge dutclk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= CHW'(NUM_AXIS_CHANNELS - 1);
         bytecnt_q <= '0;
         data_q    <= '0;
         datavld_q <= 1'b0;
         eop_q     <= 1'b0;
         chsel_q   <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         bytecnt_q <= bytecnt_d;
         data_q    <= data_d;
         datavld_q <= datavld_d;
         eop_q     <= eop_d;
         chsel_q   <= chsel_d;
      end
   end

   assign bus.txbuffer_data    = data_q;
   assign bus.txbuffer_datavld = datavld_q;
   assign bus.txbuffer_eop     = eop_q;
   assign bus.txbuffer_chsel   = chsel_q;
   assign arb_busy             = (state_q == XFER);
   assign dbg_state_o          = (state_q == XFER);

`ifdef MWAXIS_ARB_PKTCNT_EN
   logic [NUM_AXIS_CHANNELS*16-1:0] pktcnt_q, pktcnt_d;

   // Every emitted end of packet counts, including MAXPKTLEN splits; counters wrap.
   always_comb begin
      pktcnt_d = pktcnt_q;
      if (hs && eop_now) pktcnt_d[grant_q*16 +: 16] = pktcnt_q[grant_q*16 +: 16] + 16'd1;
   end

   always_ff @(posedge dutclk) begin
      if (reset) pktcnt_q <= '0;
      else       pktcnt_q <= pktcnt_d;
   end

   assign pktcnt = pktcnt_q;
`else
   assign pktcnt = '0;
`endif
endmodule

// File: tb/tb_mwaxis_tx_rr_arbiter.sv
// Bench for mwaxis_tx_rr_arbiter: packet-level reference model (rotation over pending packets, MAXPKTLEN chunking).
module tb_mwaxis_tx_rr_arbiter;
   localparam int NCH    = 8;
   localparam int DW     = 8;
   localparam int MAXLEN = 1024;
   localparam int CHW    = 3;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       first;
   } beat_t;

   logic                dutclk = 1'b0;
   logic                reset  = 1'b1;
   logic                arb_busy;
   logic [NCH*16-1:0]   pktcnt;
   logic                dbg_state;

   mwaxis_tx_rr_arbiter_if #(.NUM_AXIS_CHANNELS(NCH), .DATAWIDTH(DW), .CHW(CHW)) bus ();

   mwaxis_tx_rr_arbiter #(
      .NUM_AXIS_CHANNELS(NCH), .DATAWIDTH(DW), .MAXPKTLEN(MAXLEN), .CHW(CHW)
   ) dut (
      .dutclk(dutclk), .reset(reset), .bus(bus),
      .arb_busy(arb_busy), .pktcnt(pktcnt), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 dutclk = ~dutclk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- bench state ----------------
   int             checks   = 0;
   int             failures = 0;
   beat_t          src_q[NCH][$];
   logic [11:0]    mdl_q[NCH][$];
   logic [11:0]    exp_q[$];
   int             exp_pkt[NCH];
   int             model_last = NCH - 1;
   logic           mon_en = 1'b0, rand_gap = 1'b0, rand_afull = 1'b0, afull_force = 1'b0;
   logic [NCH-1:0] hs_pend = '0;
   int             hs_total = 0;
   logic [NCH-1:0] log_tv[$], log_rdy[$];
   logic           log_dv[$], log_eop[$];

   logic [NCH*DW-1:0] td;
   logic [NCH-1:0]    tv, tl;
   logic [11:0]       got, req;

   // ---------------- driver + monitor engine (one iteration per clock, at negedge) ----------------
   initial begin : engine
      bus.s_axis_tdata   = '0;
      bus.s_axis_tvalid  = '0;
      bus.s_axis_tlast   = '0;
      bus.txbuffer_afull = 1'b0;
      forever begin
         @(negedge dutclk);
         if (mon_en && bus.txbuffer_datavld) begin
            got = {bus.txbuffer_chsel, bus.txbuffer_eop, bus.txbuffer_data};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL out_extra: got ch/eop/data=%h, required no output", got);
            end else begin
               req = exp_q.pop_front();
               if (got !== req) begin
                  failures++;
                  $display("FAIL out_beat: got ch/eop/data=%h, required %h", got, req);
               end
            end
         end
         log_dv.push_back(bus.txbuffer_datavld);
         log_eop.push_back(bus.txbuffer_eop);
         for (int c = 0; c < NCH; c++)
            if (hs_pend[c] && src_q[c].size() > 0) src_q[c].delete(0);
         for (int c = 0; c < NCH; c++) begin
            if (src_q[c].size() > 0 && (src_q[c][0].first || !rand_gap || $urandom_range(0, 3) != 0)) begin
               tv[c] = 1'b1;
               tl[c] = src_q[c][0].last;
               td[c*DW +: DW] = src_q[c][0].data;
            end else begin
               tv[c] = 1'b0;
               tl[c] = 1'($urandom);
               td[c*DW +: DW] = 8'($urandom);
            end
         end
         bus.s_axis_tvalid  = tv;
         bus.s_axis_tlast   = tl;
         bus.s_axis_tdata   = td;
         bus.txbuffer_afull = afull_force | (rand_afull && $urandom_range(0, 3) == 0);
         #1;
         hs_pend  = bus.s_axis_tvalid & bus.s_axis_tready;
         hs_total = hs_total + $countones(hs_pend);
         log_tv.push_back(bus.s_axis_tvalid);
         log_rdy.push_back(bus.s_axis_tready);
         if (mon_en) begin
            checks++;
            if ($countones(bus.s_axis_tready) > 1) begin
               failures++;
               $display("FAIL tready_onehot: got %b, required at most one bit", bus.s_axis_tready);
            end
            checks++;
            if (bus.txbuffer_afull && bus.s_axis_tready != '0) begin
               failures++;
               $display("FAIL tready_afull: got %b with afull=1, required 0", bus.s_axis_tready);
            end
         end
      end
   end

   // ---------------- stimulus / model tasks ----------------
   task automatic step();
      @(negedge dutclk);
      #3;
   endtask

   task automatic log_clear();
      log_tv.delete(); log_rdy.delete(); log_dv.delete(); log_eop.delete();
      hs_total = 0;
   endtask

   // Queue one source packet; the model chops it into MAXLEN-byte emitted packets.
   task automatic add_packet(input int ch, input int len, input bit rnd);
      beat_t      b;
      logic [7:0] d;
      int         pos;
      for (int i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
         pos = i % MAXLEN;
         b.data = d; b.last = (i == len - 1); b.first = (pos == 0);
         src_q[ch].push_back(b);
         mdl_q[ch].push_back({3'(ch), (i == len - 1) || (pos == MAXLEN - 1), d});
      end
   endtask

   // All pending channels request at once, so emitted packets follow strict rotation after the last winner.
   task automatic plan_expected();
      int          c;
      bit          any;
      logic [11:0] w;
      c = 0;
      do begin
         any = 0;
         for (int k = 1; k <= NCH && !any; k++) begin
            c = (model_last + k) % NCH;
            if (mdl_q[c].size() > 0) any = 1;
         end
         if (any) begin
            do begin
               w = mdl_q[c].pop_front();
               exp_q.push_back(w);
            end while (!w[8]);
            exp_pkt[c]++;
            model_last = c;
         end
      end while (any);
   endtask

   function automatic bit src_busy();
      for (int c = 0; c < NCH; c++) if (src_q[c].size() > 0) return 1;
      return 0;
   endfunction

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || src_busy()) && n < budget) begin
         step();
         n++;
      end
      repeat (2) step();
      checks++;
      if (exp_q.size() > 0 || src_busy()) begin
         failures++;
         $display("FAIL %s_drain: %0d expected beats outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
         exp_q.delete();
         for (int c = 0; c < NCH; c++) src_q[c].delete();
      end
   endtask

   function automatic logic [15:0] exp_count(input int c);
`ifdef MWAXIS_ARB_PKTCNT_EN
      return 16'(exp_pkt[c]);
`else
      return 16'(c * 0);
`endif
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++; if (bus.txbuffer_datavld !== 1'b0) begin failures++; $display("FAIL rst_datavld: got %b, required 0", bus.txbuffer_datavld); end
      checks++; if (bus.txbuffer_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h, required 00", bus.txbuffer_data); end
      checks++; if (bus.txbuffer_eop !== 1'b0) begin failures++; $display("FAIL rst_eop: got %b, required 0", bus.txbuffer_eop); end
      checks++; if (bus.txbuffer_chsel !== 3'd0) begin failures++; $display("FAIL rst_chsel: got %0d, required 0", bus.txbuffer_chsel); end
      checks++; if (bus.s_axis_tready !== 8'h00) begin failures++; $display("FAIL rst_tready: got %b, required 0", bus.s_axis_tready); end
      checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", arb_busy); end
      checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL rst_state: got %b, required IDLE(0)", dbg_state); end
      checks++; if (pktcnt !== '0) begin failures++; $display("FAIL rst_pktcnt: got %h, required 0", pktcnt); end
      reset = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_single_packet();
      int i0 = -1, i1 = -1, d0 = -1, run = 0, tot = 0;
      log_clear();
      add_packet(0, 4, 0);
      plan_expected();
      wait_drain("single", 100);
      for (int i = 0; i < log_tv.size(); i++) if (i0 < 0 && log_tv[i] != '0) i0 = i;
      for (int i = 0; i < log_rdy.size(); i++) if (i1 < 0 && log_rdy[i] != '0) i1 = i;
      for (int i = 0; i < log_dv.size(); i++) begin
         if (log_dv[i]) begin
            tot++;
            if (d0 < 0) d0 = i;
            if (i - d0 == run) run++;
         end
      end
      checks++;
      if (i0 < 0 || i1 - i0 != 1) begin failures++; $display("FAIL single_ready_latency: got %0d cycles, required 1", i1 - i0); end
      checks++;
      if (i1 < 0 || log_rdy[i1] !== 8'h01) begin failures++; $display("FAIL single_ready_bit: got index %0d, required tready[0]", i1); end
      checks++;
      if (run != 4 || tot != 4) begin failures++; $display("FAIL single_dv_run: got run=%0d total=%0d, required 4/4", run, tot); end
      checks++;
      if (arb_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b, required 0", arb_busy); end
   endtask

   task automatic test_rotation();
      int d0 = -1, dl = -1, tot = 0, i1 = -1;
      log_clear();
      for (int r = 0; r < 3; r++) begin
         add_packet(1, 2, 1); add_packet(3, 2, 1); add_packet(6, 2, 1);
      end
      plan_expected();
      wait_drain("rotation", 200);
      for (int i = 0; i < log_dv.size(); i++) if (log_dv[i]) begin if (d0 < 0) d0 = i; dl = i; tot++; end
      for (int i = 0; i < log_rdy.size(); i++) if (i1 < 0 && log_rdy[i] != '0) i1 = i;
      checks++;
      if (i1 < 0 || log_rdy[i1] !== 8'b0000_0010) begin failures++; $display("FAIL rot_first_grant: got index %0d, required tready[1]", i1); end
      // 9 two-byte packets with exactly one idle cycle between consecutive packets
      checks++;
      if (tot != 18 || dl - d0 + 1 != 26) begin failures++; $display("FAIL rot_idle_gaps: got bytes=%0d span=%0d, required 18/26", tot, dl - d0 + 1); end
   endtask

   task automatic test_split();
      int neop = 0, d0 = -1, dl = -1;
      log_clear();
      add_packet(2, 2500, 1);
      plan_expected();
      wait_drain("split", 4000);
      for (int i = 0; i < log_dv.size(); i++) if (log_dv[i]) begin
         if (d0 < 0) d0 = i;
         dl = i;
         if (log_eop[i]) neop++;
      end
      checks++;
      if (neop != 3) begin failures++; $display("FAIL split_eop_count: got %0d, required 3", neop); end
      checks++;
      if (dl - d0 + 1 != 2502) begin failures++; $display("FAIL split_span: got %0d cycles, required 2502", dl - d0 + 1); end
   endtask

   task automatic test_afull_stall();
      int n = 0, f = -1, l = -1, stall = 0;
      log_clear();
      add_packet(3, 10, 1);
      plan_expected();
      while (hs_total < 2 && n < 50) begin step(); n++; end
      afull_force = 1'b1;
      repeat (5) step();
      afull_force = 1'b0;
      wait_drain("afull", 100);
      for (int i = 0; i < log_rdy.size(); i++) if (log_rdy[i][3]) begin if (f < 0) f = i; l = i; end
      for (int i = f; i >= 0 && i <= l; i++) if (!log_rdy[i][3]) stall++;
      checks++;
      if (stall != 5) begin failures++; $display("FAIL afull_stall: got %0d low cycles, required 5", stall); end
      checks++;
      if (hs_total != 10) begin failures++; $display("FAIL afull_handshakes: got %0d, required 10", hs_total); end
   endtask

   task automatic test_reset_mid();
      int n = 0, i1 = -1;
      log_clear();
      add_packet(5, 20, 1);
      plan_expected();
      while (hs_total < 5 && n < 50) begin step(); n++; end
      reset = 1'b1;
      mon_en = 1'b0;
      exp_q.delete();
      for (int c = 0; c < NCH; c++) begin src_q[c].delete(); mdl_q[c].delete(); exp_pkt[c] = 0; end
      hs_pend = '0;
      @(posedge dutclk);
      #3;
      checks++; if (bus.txbuffer_datavld !== 1'b0) begin failures++; $display("FAIL midrst_datavld: got %b, required 0", bus.txbuffer_datavld); end
      checks++; if (bus.txbuffer_data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h, required 00", bus.txbuffer_data); end
      checks++; if (bus.txbuffer_eop !== 1'b0) begin failures++; $display("FAIL midrst_eop: got %b, required 0", bus.txbuffer_eop); end
      checks++; if (bus.txbuffer_chsel !== 3'd0) begin failures++; $display("FAIL midrst_chsel: got %0d, required 0", bus.txbuffer_chsel); end
      checks++; if (bus.s_axis_tready !== 8'h00) begin failures++; $display("FAIL midrst_tready: got %b, required 0", bus.s_axis_tready); end
      checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b, required 0", arb_busy); end
      checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL midrst_state: got %b, required IDLE(0)", dbg_state); end
      checks++; if (pktcnt !== '0) begin failures++; $display("FAIL midrst_pktcnt: got %h, required 0", pktcnt); end
      step();
      reset = 1'b0;
      model_last = NCH - 1;
      log_clear();
      mon_en = 1'b1;
      add_packet(5, 3, 1);
      add_packet(0, 3, 1);
      plan_expected();
      wait_drain("midrst", 100);
      for (int i = 0; i < log_rdy.size(); i++) if (i1 < 0 && log_rdy[i] != '0) i1 = i;
      checks++;
      if (i1 < 0 || log_rdy[i1] !== 8'h01) begin failures++; $display("FAIL midrst_first_grant: got index %0d, required tready[0]", i1); end
   endtask

   task automatic test_pktcnt();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      model_last = NCH - 1;
      for (int c = 0; c < NCH; c++) exp_pkt[c] = 0;
      for (int p = 0; p < 3; p++) add_packet(4, $urandom_range(1, 20), 1);
      add_packet(7, 1030, 1);
      plan_expected();
      wait_drain("pktcnt", 2000);
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (pktcnt[c*16 +: 16] !== exp_count(c)) begin
            failures++;
            $display("FAIL pktcnt_ch%0d: got %0d, required %0d", c, pktcnt[c*16 +: 16], exp_count(c));
         end
      end
   endtask

   task automatic test_random();
      rand_gap = 1'b1;
      rand_afull = 1'b1;
      for (int b = 0; b < 4; b++) begin
         for (int p = 0; p < 20; p++) add_packet($urandom_range(0, NCH - 1), $urandom_range(1, 48), 1);
         plan_expected();
         wait_drain("random", 20000);
      end
      rand_gap = 1'b0;
      rand_afull = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (pktcnt[c*16 +: 16] !== exp_count(c)) begin
            failures++;
            $display("FAIL rand_pktcnt_ch%0d: got %0d, required %0d", c, pktcnt[c*16 +: 16], exp_count(c));
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      for (int c = 0; c < NCH; c++) exp_pkt[c] = 0;
      test_reset();
      test_single_packet();
      test_rotation();
      test_split();
      test_afull_stall();
      test_reset_mid();
      test_pktcnt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
